// File: rtl/wb_ins_dat_arbiter.sv
// Round-robin arbiter that shares one Wishbone slave between an instruction
// master (m0) and a data master (m1), with a per-grant stall watchdog.
module wb_ins_dat_arbiter #(
    parameter int AWIDTH = 32,
    parameter int TWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [AWIDTH-1:0] m0_adr_i,
    input  logic [31:0]       m0_dat_i,
    output logic [31:0]       m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [AWIDTH-1:0] m1_adr_i,
    input  logic [31:0]       m1_dat_i,
    output logic [31:0]       m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic [AWIDTH-1:0] s_adr_o,
    output logic [31:0]       s_dat_o,
    input  logic [31:0]       s_dat_i,
    input  logic              s_ack_i,

    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_e;

    localparam logic [TWIDTH-1:0] CNT_LIMIT = '1;
    localparam logic [TWIDTH-1:0] CNT_ONE   = TWIDTH'(1);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [TWIDTH-1:0] cnt_q, cnt_d, cnt_inc;

    logic gnt0, gnt1, granted;
    logic own_cyc, own_stb;
    logic wd_fire;

    assign gnt0    = (state_q == ST_G0);
    assign gnt1    = (state_q == ST_G1);
    assign granted = gnt0 | gnt1;

    assign own_cyc = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
    assign own_stb = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);

    // The watchdog fires in the cycle where the count of unanswered strobes
    // reaches the limit; an ack in that same cycle takes precedence.
    assign cnt_inc = cnt_q + CNT_ONE;
    assign wd_fire = own_cyc & own_stb & ~s_ack_i & (cnt_inc == CNT_LIMIT);

    // NOTE: every signal written in a combinational block gets a default first,
    // otherwise any path that skips an assignment infers a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? ST_G0 : ST_G1;
                end else if (m0_cyc_i) begin
                    state_d = ST_G0;
                end else if (m1_cyc_i) begin
                    state_d = ST_G1;
                end
            end
            ST_G0: begin
                if (!m0_cyc_i || wd_fire) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end
            end
            ST_G1: begin
                if (!m1_cyc_i || wd_fire) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || s_ack_i) begin
            cnt_d = '0;
        end else if (granted && own_stb) begin
            cnt_d = cnt_inc;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, matching real hardware.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave-side request mux; everything decodes from state_q so reset clears it at once.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        case (state_q)
            ST_G0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            ST_G1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;

    assign m0_ack_o  = gnt0 & s_ack_i & m0_cyc_i & m0_stb_i;
    assign m1_ack_o  = gnt1 & s_ack_i & m1_cyc_i & m1_stb_i;
    assign m0_err_o  = gnt0 & wd_fire;
    assign m1_err_o  = gnt1 & wd_fire;

    assign grant_o   = {gnt1, gnt0};
    assign timeout_o = wd_fire;

endmodule

// File: tb/tb_wb_ins_dat_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a cycle-level ownership model of the arbiter.
module tb_wb_ins_dat_arbiter;

    localparam int AW    = 32;
    localparam int TW    = 4;
    localparam int LIMIT = (1 << TW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]    m0_sel, m1_sel;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [31:0]   m0_dat, m1_dat, s_dat_in;
    logic          s_ack;

    logic [31:0]   m0_dat_o, m1_dat_o, s_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o, timeout_o;
    logic [3:0]    s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [1:0]    grant_o;

    wb_ins_dat_arbiter #(.AWIDTH(AW), .TWIDTH(TW)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_in), .s_ack_i(s_ack),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: who owns the slave, who was served last, stalled strobes so far.
    int owner  = -1;
    int last   = 1;
    int waited = 0;

    logic          obs_m0_ack, obs_m1_ack, obs_m0_err, obs_tmo;
    logic [AW-1:0] obs_adr;
    int            served[$];
    logic          stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        last   = 1;
        waited = 0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        logic [6:0]    e_bus;
        logic [AW-1:0] e_adr;
        logic [31:0]   e_wdat;
        logic [1:0]    e_grant;
        logic          c, s, fire;
        @(negedge clk);
        e_bus = '0; e_adr = '0; e_wdat = '0; e_grant = 2'b00;
        if (owner == 0) begin
            e_bus = {m0_cyc, m0_stb, m0_we, m0_sel}; e_adr = m0_adr; e_wdat = m0_dat; e_grant = 2'b01;
        end else if (owner == 1) begin
            e_bus = {m1_cyc, m1_stb, m1_we, m1_sel}; e_adr = m1_adr; e_wdat = m1_dat; e_grant = 2'b10;
        end
        c    = e_bus[6];
        s    = e_bus[5];
        fire = (owner >= 0) && c && s && !s_ack && (waited + 1 == LIMIT);
        check("grant", 64'(grant_o), 64'(e_grant));
        check("s_bus", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 64'(e_bus));
        check("s_adr", 64'(s_adr_o), 64'(e_adr));
        check("s_wdat", 64'(s_dat_o), 64'(e_wdat));
        check("resp", 64'({m1_err_o, m1_ack_o, m0_err_o, m0_ack_o}),
              64'({owner == 1 && fire, owner == 1 && s_ack && c && s,
                   owner == 0 && fire, owner == 0 && s_ack && c && s}));
        check("timeout", 64'(timeout_o), 64'(fire));
        check("rdat", 64'({m1_dat_o, m0_dat_o}), {s_dat_in, s_dat_in});
        obs_m0_ack = m0_ack_o;
        obs_m1_ack = m1_ack_o;
        obs_m0_err = m0_err_o;
        obs_tmo    = timeout_o;
        obs_adr    = s_adr_o;
        @(posedge clk);
        if (owner < 0) begin
            waited = 0;
            if (m0_cyc && m1_cyc) owner = (last == 1) ? 0 : 1;
            else if (m0_cyc)      owner = 0;
            else if (m1_cyc)      owner = 1;
        end else if (!c || fire) begin
            last   = owner;
            owner  = -1;
            waited = 0;
        end else if (s_ack) begin
            waited = 0;
        end else if (s) begin
            waited++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {m0_cyc, m0_stb, m0_we, m0_sel, m0_adr, m0_dat} = '0;
        {m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_dat} = '0;
        s_ack    = 1'b0;
        s_dat_in = 32'hA5A5_0001;
        #1 rst = 1'b0;
        #1;
        check("rst_grant", 64'(grant_o), 64'(2'b00));
        check("rst_s_cyc", 64'({s_cyc_o, s_stb_o, timeout_o, m0_ack_o, m1_ack_o}), 64'(0));
        check("rst_rdat", 64'(m0_dat_o), 64'(32'hA5A5_0001));
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;

        // Tie after reset: m0 first, dead cycle, then m1.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10; m0_sel = 4'hF;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20; m1_sel = 4'h3; m1_we = 1; m1_dat = 32'h1234_5678;
        step();
        check("tie_grant_m0", 64'(grant_o), 64'(2'b01));
        s_ack = 1; step();
        check("tie_m0_acked", 64'(obs_m0_ack), 64'(1));
        m0_cyc = 0; m0_stb = 0; s_ack = 0; step();
        check("tie_dead_cycle", 64'(grant_o), 64'(2'b00));
        step();
        check("tie_grant_m1", 64'(grant_o), 64'(2'b10));
        s_ack = 1; step();
        m1_cyc = 0; m1_stb = 0; s_ack = 0; step();
        step();

        // Sustained contention with single-beat masters that re-request right away.
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
        repeat (16) begin
            step();
            if (obs_m0_ack) served.push_back(0);
            if (obs_m1_ack) served.push_back(1);
            m0_cyc = !obs_m0_ack; m0_stb = m0_cyc;
            m1_cyc = !obs_m1_ack; m1_stb = m1_cyc;
        end
        check("rr_count", 64'(served.size()), 64'(5));
        for (int i = 0; i < 4; i++) check("rr_order", 64'(served[i]), 64'(i % 2));
        {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = '0;
        step(); step();

        // Burst hold: m1 keeps cyc for four acked beats while m0 waits.
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h100; step();
        m0_cyc = 1; m0_stb = 1; s_ack = 1;
        for (int b = 0; b < 4; b++) begin
            m1_adr = 32'h100 + 32'(4 * b);
            m1_dat = $urandom();
            step();
            check("burst_adr", 64'(obs_adr), 64'(32'h100 + 32'(4 * b)));
            check("burst_m0_ack", 64'(obs_m0_ack), 64'(0));
            check("burst_m1_ack", 64'(obs_m1_ack), 64'(1));
        end
        m1_cyc = 0; m1_stb = 0; s_ack = 0; step();
        check("burst_dead", 64'(grant_o), 64'(2'b00));
        step();
        check("burst_m0_grant", 64'(grant_o), 64'(2'b01));
        s_ack = 1; step();
        m0_cyc = 0; m0_stb = 0; s_ack = 0; step();
        step();

        // Watchdog: no ack, error on the 15th stalled strobe, then a fresh grant.
        m0_cyc = 1; m0_stb = 1; step();
        for (int k = 1; k <= LIMIT; k++) begin
            step();
            check("wd_err", 64'(obs_m0_err), 64'(k == LIMIT));
            check("wd_tmo", 64'(obs_tmo), 64'(k == LIMIT));
        end
        check("wd_idle", 64'(grant_o), 64'(2'b00));
        step();
        check("wd_regrant", 64'(grant_o), 64'(2'b01));
        for (int k = 1; k <= LIMIT; k++) begin
            s_ack = (k == LIMIT);
            step();
            check("wd_ack_no_err", 64'(obs_m0_err), 64'(0));
        end
        check("wd_ack_wins", 64'(obs_m0_ack), 64'(1));
        m0_cyc = 0; m0_stb = 0; s_ack = 0; step();
        step();

        // Reset while m1 owns the slave with a strobe outstanding.
        m1_cyc = 1; m1_stb = 1; step();
        check("mid_g1", 64'(grant_o), 64'(2'b10));
        #2;
        s_ack = 1;
        rst = 1'b0;
        #1;
        check("mid_rst_cyc", 64'(s_cyc_o), 64'(0));
        check("mid_rst_grant", 64'(grant_o), 64'(2'b00));
        check("mid_rst_m1_ack", 64'(m1_ack_o), 64'(0));
        model_reset();
        @(posedge clk); #1;
        m0_cyc = 1; m0_stb = 1;
        rst = 1'b1;
        step();
        check("post_rst_tie", 64'(grant_o), 64'(2'b01));
        {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = '0;
        step(); step();

        // Random traffic with alternating normal and stalling slave phases.
        stall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) stall = ($urandom_range(0, 2) == 0);
            m0_cyc = m0_cyc ? ($urandom_range(0, 99) < (stall ? 98 : 85)) : ($urandom_range(0, 99) < 30);
            m1_cyc = m1_cyc ? ($urandom_range(0, 99) < (stall ? 98 : 85)) : ($urandom_range(0, 99) < 30);
            m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
            m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
            m0_we  = 1'($urandom_range(0, 1));
            m1_we  = 1'($urandom_range(0, 1));
            m0_sel = 4'($urandom_range(0, 15));
            m1_sel = 4'($urandom_range(0, 15));
            m0_adr = $urandom();
            m1_adr = $urandom();
            m0_dat = $urandom();
            m1_dat = $urandom();
            s_dat_in = $urandom();
            s_ack  = ($urandom_range(0, 99) < (stall ? 2 : 40));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
